// File: rtl/cu_output_arbiter.sv
// rtl/cu_output_arbiter.sv - round-robin sharing of the output pins between two compute units
module cu_output_arbiter #(
  parameter int HOLD_CYCLES = 1,
  parameter int DEPTH       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       cu0_valid,
  output logic       cu0_ready,
  input  logic [7:0] cu0_data,
  input  logic [3:0] cu0_reg_id,
  input  logic       cu1_valid,
  output logic       cu1_ready,
  input  logic [7:0] cu1_data,
  input  logic [3:0] cu1_reg_id,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t        state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          rr_q, rr_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    reg_id_q, reg_id_d;
  logic          src_q, src_d;
  logic          strobe_q, strobe_d;
  logic          pending_q, pending_d;
  logic [7:0]    oe_q, oe_d;

  // Each FIFO entry is {reg_id, data}
  logic [11:0]   mem0_q [DEPTH];
  logic [11:0]   mem0_d [DEPTH];
  logic [11:0]   mem1_q [DEPTH];
  logic [11:0]   mem1_d [DEPTH];
  logic [AW-1:0] wp0_q, wp0_d, rp0_q, rp0_d;
  logic [AW-1:0] wp1_q, wp1_d, rp1_q, rp1_d;
  logic [CW-1:0] fill0_q, fill0_d, fill1_q, fill1_d;

  logic          empty0, empty1, full0, full1;
  logic          push0, push1, pop0, pop1;
  logic          grant;
  logic [11:0]   head;

  // Ready depends only on reset, enable and the registered fill levels
  always_comb begin
    empty0    = (fill0_q == '0);
    empty1    = (fill1_q == '0);
    full0     = (fill0_q == CW'(DEPTH));
    full1     = (fill1_q == CW'(DEPTH));
    cu0_ready = rst_n && ena && !full0;
    cu1_ready = rst_n && ena && !full1;
    push0     = cu0_valid && cu0_ready;
    push1     = cu1_valid && cu1_ready;
  end

  // FIFO writes, load arbitration and hold countdown
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rr_d     = rr_q;
    data_d   = data_q;
    reg_id_d = reg_id_q;
    src_d    = src_q;
    strobe_d = 1'b0;
    oe_d     = 8'hFF;
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wp0_d    = wp0_q;
    wp1_d    = wp1_q;
    rp0_d    = rp0_q;
    rp1_d    = rp1_q;
    pop0     = 1'b0;
    pop1     = 1'b0;
    grant    = 1'b0;
    head     = '0;

    if (push0) begin
      mem0_d[wp0_q] = {cu0_reg_id, cu0_data};
      wp0_d         = wp0_q + AW'(1);
    end
    if (push1) begin
      mem1_d[wp1_q] = {cu1_reg_id, cu1_data};
      wp1_d         = wp1_q + AW'(1);
    end

    if (ena) begin
      if (state_q == ST_IDLE || hold_q == 8'd0) begin
        if (!empty0 || !empty1) begin
          // A lone requester wins outright; two requesters go to rr
          grant    = empty0 ? 1'b1 : (empty1 ? 1'b0 : rr_q);
          pop0     = !grant;
          pop1     = grant;
          head     = grant ? mem1_q[rp1_q] : mem0_q[rp0_q];
          data_d   = head[7:0];
          reg_id_d = head[11:8];
          src_d    = grant;
          rr_d     = !grant;
          hold_d   = HOLD_M1;
          state_d  = ST_HOLD;
          strobe_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end else begin
        hold_d = hold_q - 8'd1;
      end
    end

    if (pop0) rp0_d = rp0_q + AW'(1);
    if (pop1) rp1_d = rp1_q + AW'(1);
    fill0_d   = fill0_q + CW'(push0) - CW'(pop0);
    fill1_d   = fill1_q + CW'(push1) - CW'(pop1);
    pending_d = (fill0_d != '0) || (fill1_d != '0);
  end

  // Control and output registers; reset discards queued and held words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      rr_q      <= 1'b0;
      data_q    <= '0;
      reg_id_q  <= '0;
      src_q     <= 1'b0;
      strobe_q  <= 1'b0;
      pending_q <= 1'b0;
      oe_q      <= '0;
      wp0_q     <= '0;
      wp1_q     <= '0;
      rp0_q     <= '0;
      rp1_q     <= '0;
      fill0_q   <= '0;
      fill1_q   <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      rr_q      <= rr_d;
      data_q    <= data_d;
      reg_id_q  <= reg_id_d;
      src_q     <= src_d;
      strobe_q  <= strobe_d;
      pending_q <= pending_d;
      oe_q      <= oe_d;
      wp0_q     <= wp0_d;
      wp1_q     <= wp1_d;
      rp0_q     <= rp0_d;
      rp1_q     <= rp1_d;
      fill0_q   <= fill0_d;
      fill1_q   <= fill1_d;
    end
  end

  // FIFO storage needs no reset; the fill counters define validity
  always_ff @(posedge clk) begin
    mem0_q <= mem0_d;
    mem1_q <= mem1_d;
  end

  assign uo_out  = data_q;
  assign uio_out = {pending_q, (state_q == ST_HOLD), strobe_q, src_q, reg_id_q};
  assign uio_oe  = oe_q;

endmodule
